// File: rtl/ieee_int2float.sv
// Sequential 32-bit integer to IEEE-754 single converter; accept edge to out_valid takes lz+3 edges (1 for zero).
// Holds the result and stays out of IDLE until out_ready is seen, so no new operand is taken while the output is stalled.
module ieee_int2float #(
    parameter int RND_EN = 1,
    parameter int BIAS   = 127
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        opc,
    input  logic [31:0] A,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [31:0] out,
    output logic        out_valid,
    input  logic        out_ready
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_NORM  = 2'd1;
    localparam logic [1:0] S_ROUND = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [7:0] EXP_TOP = 8'(BIAS + 31);

    logic [1:0]  state;
    logic [31:0] mag;
    logic [7:0]  expo;
    logic        sign;

    logic [22:0] m;
    logic        g;
    logic        s_bit;
    logic        rnd_up;
    logic [23:0] m_inc;

    // Guard is the first discarded bit, sticky ORs the remaining seven.
    always_comb begin
        m      = mag[30:8];
        g      = mag[7];
        s_bit  = |mag[6:0];
        rnd_up = (RND_EN != 0) && g && (s_bit || m[0]);
        m_inc  = {1'b0, m} + 24'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            mag   <= '0;
            expo  <= '0;
            sign  <= 1'b0;
            out   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        if (A == 32'd0) begin
                            out   <= '0;
                            state <= S_DONE;
                        end else begin
                            sign  <= ~opc & A[31];
                            mag   <= (~opc & A[31]) ? (~A + 32'd1) : A;
                            expo  <= EXP_TOP;
                            state <= S_NORM;
                        end
                    end
                end
                S_NORM: begin
                    if (mag[31]) begin
                        state <= S_ROUND;
                    end else begin
                        mag  <= mag << 1;
                        expo <= expo - 8'd1;
                    end
                end
                S_ROUND: begin
                    // A carry out of the mantissa leaves it zero and bumps the exponent.
                    if (rnd_up)
                        out <= {sign, expo + {7'd0, m_inc[23]}, m_inc[22:0]};
                    else
                        out <= {sign, expo, m};
                    state <= S_DONE;
                end
                S_DONE: begin
                    if (out_ready)
                        state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = (state == S_IDLE);
    assign out_valid = (state == S_DONE);

endmodule

// File: tb/tb_ieee_int2float.sv
// Bench for ieee_int2float: rounding and truncating instances driven in parallel against an arithmetic reference model.
module tb_ieee_int2float;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        opc = 1'b0;
    logic [31:0] A = '0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;
    logic        in_ready, out_valid, in_ready_t, out_valid_t;
    logic [31:0] out, out_t;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    ieee_int2float #(.RND_EN(1), .BIAS(127)) dut (
        .clk(clk), .rst(rst), .opc(opc), .A(A), .in_valid(in_valid),
        .in_ready(in_ready), .out(out), .out_valid(out_valid), .out_ready(out_ready)
    );

    ieee_int2float #(.RND_EN(0), .BIAS(127)) dut_t (
        .clk(clk), .rst(rst), .opc(opc), .A(A), .in_valid(in_valid),
        .in_ready(in_ready_t), .out(out_t), .out_valid(out_valid_t), .out_ready(out_ready)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    function automatic longint ref_mag(input logic [31:0] a, input logic uns);
        longint v;
        v = longint'({32'h0, a});
        if (!uns && a[31]) v = (longint'(1) << 32) - v;
        return v;
    endfunction

    function automatic int msb_pos(input longint v);
        int p;
        p = 0;
        for (int i = 0; i < 33; i++) if (v[i]) p = i;
        return p;
    endfunction

    // Exact value scaled to a 24-bit significand, then nearest-even or truncation on the remainder.
    function automatic logic [31:0] ref_conv(input logic [31:0] a, input logic uns, input bit rnd);
        longint v, q, rem, half;
        int p, e, sh;
        logic s;
        if (a == 32'd0) return 32'd0;
        s = !uns && a[31];
        v = ref_mag(a, uns);
        p = msb_pos(v);
        e = 127 + p;
        if (p <= 23) begin
            q = v << (23 - p);
        end else begin
            sh   = p - 23;
            q    = v >> sh;
            rem  = v - (q << sh);
            half = longint'(1) << (sh - 1);
            if (rnd && (rem > half || (rem == half && q[0]))) q = q + 1;
            if (q == (longint'(1) << 24)) begin
                q = q >> 1;
                e = e + 1;
            end
        end
        return {s, 8'(e), q[22:0]};
    endfunction

    function automatic int ref_lat(input logic [31:0] a, input logic uns);
        if (a == 32'd0) return 1;
        return (31 - msb_pos(ref_mag(a, uns))) + 3;
    endfunction

    // Accepts one operand and waits (bounded) for both results; leaves the caller just after the out_valid edge.
    task automatic convert(input string tag, input logic [31:0] a, input logic mode,
                           input logic [31:0] exp_r, input logic [31:0] exp_t);
        int edges;
        @(negedge clk);
        check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
        A = a;
        opc = mode;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        edges = 1;
        while (!out_valid && edges < 60) begin
            @(posedge clk);
            #1;
            edges++;
        end
        check({tag, "_valid"}, {30'd0, out_valid, out_valid_t}, 32'd3);
        check({tag, "_latency"}, 32'(edges), 32'(ref_lat(a, mode)));
        check({tag, "_rne"}, out, exp_r);
        check({tag, "_trunc"}, out_t, exp_t);
    endtask

    task automatic handshake(input string tag, input logic [31:0] exp_r);
        @(posedge clk);
        #1;
        check({tag, "_valid_drop"}, {31'd0, out_valid}, 32'd0);
        check({tag, "_ready_back"}, {31'd0, in_ready}, 32'd1);
        check({tag, "_held"}, out, exp_r);
    endtask

    task automatic run_model(input string tag, input logic [31:0] a, input logic mode);
        logic [31:0] er;
        er = ref_conv(a, mode, 1'b1);
        convert(tag, a, mode, er, ref_conv(a, mode, 1'b0));
        handshake(tag, er);
    endtask

    initial begin
        logic [31:0] r;
        repeat (2) @(posedge clk);
        #1;
        check("reset_out", out, 32'd0);
        check("reset_valid", {31'd0, out_valid}, 32'd0);
        check("reset_in_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        rst = 1'b0;

        convert("one", 32'h00000001, 1'b0, 32'h3F800000, 32'h3F800000);
        handshake("one", 32'h3F800000);
        convert("minus_one", 32'hFFFFFFFF, 1'b0, 32'hBF800000, 32'hBF800000);
        handshake("minus_one", 32'hBF800000);
        convert("int_min", 32'h80000000, 1'b0, 32'hCF000000, 32'hCF000000);
        handshake("int_min", 32'hCF000000);
        convert("u_2p31", 32'h80000000, 1'b1, 32'h4F000000, 32'h4F000000);
        handshake("u_2p31", 32'h4F000000);
        convert("zero", 32'h00000000, 1'b0, 32'h00000000, 32'h00000000);
        handshake("zero", 32'h00000000);
        convert("tie_even", 32'h01000001, 1'b1, 32'h4B800000, 32'h4B800000);
        handshake("tie_even", 32'h4B800000);
        convert("tie_up", 32'h01000003, 1'b1, 32'h4B800002, 32'h4B800001);
        handshake("tie_up", 32'h4B800002);
        convert("wrap", 32'hFFFFFFFF, 1'b1, 32'h4F800000, 32'h4F7FFFFF);
        handshake("wrap", 32'h4F800000);

        // Stall the output and offer a competing operand that must be ignored.
        @(negedge clk);
        out_ready = 1'b0;
        convert("bp", 32'h00001234, 1'b1, 32'h4591A000, 32'h4591A000);
        @(negedge clk);
        A = 32'h00000007;
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            check("bp_valid_hold", {31'd0, out_valid}, 32'd1);
            check("bp_out_hold", out, 32'h4591A000);
            check("bp_in_ready", {31'd0, in_ready}, 32'd0);
        end
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b1;
        handshake("bp", 32'h4591A000);
        @(posedge clk);
        #1;
        check("bp_no_accept", {30'd0, out_valid, in_ready}, 32'd1);

        // Asynchronous reset part-way through normalisation.
        @(negedge clk);
        A = 32'h00000001;
        opc = 1'b0;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("arst_out", out, 32'd0);
        check("arst_valid", {31'd0, out_valid}, 32'd0);
        check("arst_in_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        rst = 1'b0;
        convert("hundred", 32'h00000064, 1'b0, 32'h42C80000, 32'h42C80000);
        handshake("hundred", 32'h42C80000);

        for (int i = 0; i < 8; i++) begin
            r = $urandom;
            if (i == 3) r = r >> $urandom_range(1, 30);
            run_model($sformatf("rand_s%0d", i), r, 1'b0);
        end
        for (int i = 0; i < 4; i++) begin
            r = $urandom;
            run_model($sformatf("rand_u%0d", i), r, 1'b1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
